// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC flow-control sequencer.
package pc_seq_pkg;

  localparam int PC_W  = 16;
  localparam int CNT_W = 4;

  localparam logic [PC_W-1:0] DEFAULT_VECTOR = 16'h0010;

  // RUN: normal flow, ISR: servicing an interrupt, HOLD: post-RETI hold-off
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    ISR  = 2'd1,
    HOLD = 2'd2
  } seq_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register an
// in-flight load in EX has not yet written back.
module hazard_detect #(
  parameter int REG_W = 4
) (
  input  logic             mem_rd,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  output logic             hazard
);

  // Register 0 is hardwired, so a load targeting it never creates a hazard
  always_comb begin
    hazard = mem_rd && (rd != '0) &&
             ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC flow-control sequencer: prioritises RETI, branches, interrupt entry and
// load-use stalls, keeps the saved return address and the interrupt FSM.
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] VECTOR  = DEFAULT_VECTOR,
  parameter int              HOLDOFF = 2,
  parameter int              REG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_taken_EX,
  input  logic [PC_W-1:0]  br_tgt_EX,
  input  logic             reti_EX,
  input  logic [PC_W-1:0]  pc_ID_EX,
  input  logic             mem_rd_ID_EX,
  input  logic [REG_W-1:0] rd_ID_EX,
  input  logic [REG_W-1:0] rs1_IM_ID,
  input  logic [REG_W-1:0] rs2_IM_ID,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic             irq,
  input  logic             irq_en,
  output logic             stall_IM_ID,
  output logic             flush_IM_ID,
  output logic             flush_ID_EX,
  output logic             flow_change,
  output logic [PC_W-1:0]  dst,
  output logic             irq_ack,
  output logic [PC_W-1:0]  epc,
  output logic             in_isr
);

  localparam logic [CNT_W-1:0] HOLDOFF_CNT = CNT_W'(HOLDOFF);

  seq_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             hazard;
  logic             epc_load;
  logic             stall_c, flush_im_c, flush_id_c, flow_c, ack_c;
  logic [PC_W-1:0]  dst_c;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .mem_rd  (mem_rd_ID_EX),
    .rd      (rd_ID_EX),
    .rs1     (rs1_IM_ID),
    .rs2     (rs2_IM_ID),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2),
    .hazard  (hazard)
  );

  // Priority mux for redirects/stalls plus FSM next-state and hold-off count
  always_comb begin
    stall_c    = 1'b0;
    flush_im_c = 1'b0;
    flush_id_c = 1'b0;
    flow_c     = 1'b0;
    ack_c      = 1'b0;
    dst_c      = '0;
    epc_load   = 1'b0;
    state_next = state;
    cnt_next   = cnt;

    if (state == ISR && reti_EX) begin
      flow_c     = 1'b1;
      dst_c      = epc;
      flush_im_c = 1'b1;
      flush_id_c = 1'b1;
      if (HOLDOFF == 0) begin
        state_next = RUN;
        cnt_next   = '0;
      end else begin
        state_next = HOLD;
        cnt_next   = HOLDOFF_CNT;
      end
    end else begin
      if (br_taken_EX) begin
        flow_c     = 1'b1;
        dst_c      = br_tgt_EX;
        flush_im_c = 1'b1;
        flush_id_c = 1'b1;
      end else if (state == RUN && irq && irq_en) begin
        flow_c     = 1'b1;
        dst_c      = VECTOR;
        flush_im_c = 1'b1;
        flush_id_c = 1'b1;
        ack_c      = 1'b1;
        epc_load   = 1'b1;
        state_next = ISR;
      end else if (hazard) begin
        stall_c    = 1'b1;
        flush_id_c = 1'b1;
      end

      // Hold-off keeps counting regardless of branches in flight
      if (state == HOLD) begin
        if (cnt <= 4'd1) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
    end
  end

  // FSM state, hold-off counter and saved return address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      cnt    <= '0;
      epc    <= '0;
      in_isr <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      in_isr <= (state_next == ISR);
      if (epc_load) begin
        epc <= pc_ID_EX;
      end
    end
  end

  // Combinational controls are forced low while reset is held
  always_comb begin
    stall_IM_ID = rst_n & stall_c;
    flush_IM_ID = rst_n & flush_im_c;
    flush_ID_EX = rst_n & flush_id_c;
    flow_change = rst_n & flow_c;
    irq_ack     = rst_n & ack_c;
    dst         = rst_n ? dst_c : '0;
  end

endmodule
